// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned BAUD_W_DEF = 20;
    localparam int unsigned K_MIN      = 4;
    localparam int unsigned SHIFT_W    = 10;
    localparam int unsigned NBITS_W    = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/uart_rx_engine.sv
// UART serial receive engine: start-bit validation, mid-bit sampling,
// 7/8-bit reassembly with optional parity, and error reporting.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_W = BAUD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [BAUD_W-1:0] k,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic              rdy_in,
    output logic [7:0]        rx_data,
    output logic              rx_done,
    output logic              perr,
    output logic              ferr,
    output logic              ovf
);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;

    logic                 w_rx_s;
    logic                 r_rx_prev;
    logic                 w_fall;

    logic [BAUD_W-1:0]    r_cnt;
    logic [BAUD_W-1:0]    r_k;
    logic [BAUD_W-1:0]    w_k_eff;
    logic [BAUD_W-1:0]    w_half;
    logic                 w_half_tc;
    logic                 w_bit_tc;

    logic [NBITS_W-1:0]   r_bit_cnt;
    logic [NBITS_W-1:0]   w_nbits;
    logic                 w_last_bit;
    logic [SHIFT_W-1:0]   r_shift;
    logic [SHIFT_W-1:0]   w_frame;

    logic                 r_eight;
    logic                 r_pen;
    logic                 r_ohel;

    logic [7:0]           w_data;
    logic                 w_par_bit;
    logic                 w_par_exp;
    logic                 w_stop_bit;
    logic                 w_perr;

    logic [7:0]           r_rx_data;
    logic                 r_rx_done;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovf;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    assign w_fall  = r_rx_prev & ~w_rx_s;
    assign w_k_eff = (k < BAUD_W'(K_MIN)) ? BAUD_W'(K_MIN) : k;

    // START ends half a bit after the edge; the detection cycle counts as one.
    assign w_half     = r_k >> 1;
    assign w_half_tc  = (r_cnt == (w_half - BAUD_W'(2)));
    assign w_bit_tc   = (r_cnt == (r_k - BAUD_W'(1)));

    assign w_nbits    = NBITS_W'(8) + {3'b000, r_eight} + {3'b000, r_pen};
    assign w_last_bit = (r_bit_cnt == (w_nbits - NBITS_W'(1)));

    // Samples enter at the MSB, so a short frame sits in the upper bits.
    assign w_frame    = r_shift >> (NBITS_W'(SHIFT_W) - w_nbits);
    assign w_data     = r_eight ? w_frame[7:0] : {1'b0, w_frame[6:0]};
    assign w_par_bit  = r_eight ? w_frame[8] : w_frame[7];
    assign w_stop_bit = w_frame[w_nbits - NBITS_W'(1)];
    assign w_par_exp  = (r_ohel == PAR_ODD) ? ~^w_data : ^w_data;
    assign w_perr     = r_pen & (w_par_bit != w_par_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_half_tc) begin
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_tc && w_last_bit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Baud/bit counters, frame configuration latch and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_k       <= BAUD_W'(K_MIN);
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_eight   <= 1'b0;
            r_pen     <= 1'b0;
            r_ohel    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_k       <= w_k_eff;
                        r_eight   <= eight;
                        r_pen     <= pen;
                        r_ohel    <= ohel;
                    end
                end
                ST_START: begin
                    r_cnt <= w_half_tc ? '0 : r_cnt + BAUD_W'(1);
                end
                ST_DATA: begin
                    if (w_bit_tc) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[SHIFT_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + NBITS_W'(1);
                    end else begin
                        r_cnt <= r_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Result registers hold until the next completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= '0;
            r_rx_done <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (r_state == ST_DONE) begin
                r_rx_done <= 1'b1;
                r_rx_data <= w_data;
                r_perr    <= w_perr;
                r_ferr    <= ~w_stop_bit;
                r_ovf     <= rdy_in;
            end
        end
    end

    assign rx_data = r_rx_data;
    assign rx_done = r_rx_done;
    assign perr    = r_perr;
    assign ferr    = r_ferr;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: table of frames plus hand-built corner sequences.
module tb_uart_rx_engine;

    localparam int unsigned BAUD_W = 20;

    logic              clk;
    logic              rst;
    logic              rx;
    logic [BAUD_W-1:0] k;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic              rdy_in;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              perr;
    logic              ferr;
    logic              ovf;

    typedef struct {
        logic       eight;
        logic       pen;
        logic       ohel;
        logic       rdy;
        logic       flip;
        logic       stop;
        logic [7:0] data;
        int         k;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
        int         start_cyc;
        int         lat;
    } exp_t;

    exp_t q[$];
    vec_t tbl[9];
    int   n_vec;
    int   n_err;
    int   done_cnt;
    int   cyc;

    uart_rx_engine #(.BAUD_W(BAUD_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .k       (k),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .rdy_in  (rdy_in),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic e8, input logic p, input logic o, input logic r,
                                input logic f, input logic s, input logic [7:0] d, input int kk);
        vec_t v;
        v.eight = e8; v.pen = p; v.ohel = o; v.rdy = r;
        v.flip = f; v.stop = s; v.data = d; v.k = kk;
        return v;
    endfunction

    task automatic monitor();
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) begin
                done_cnt++;
                chk("done_width", 32'(prev_done), 32'd0);
                chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.data));
                    chk("perr", 32'(perr), 32'(e.perr));
                    chk("ferr", 32'(ferr), 32'(e.ferr));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                end
            end
            prev_done = rx_done;
        end
    endtask

    task automatic hold_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame and pushes the expected result; config is scrambled
    // after the start bit so the DUT must use its latched copy.
    task automatic send_frame(input vec_t v, input bit hold_low);
        exp_t       e;
        logic [7:0] d;
        logic       par;
        int         keff;
        int         nd;
        int         nbits;
        keff  = (v.k < 4) ? 4 : v.k;
        d     = v.eight ? v.data : {1'b0, v.data[6:0]};
        par   = (v.ohel ? ~^d : ^d) ^ v.flip;
        nd    = v.eight ? 8 : 7;
        nbits = nd + int'(v.pen) + 1;
        k      = BAUD_W'(v.k);
        eight  = v.eight;
        pen    = v.pen;
        ohel   = v.ohel;
        rdy_in = v.rdy;
        rx     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        e.data = d;
        e.perr = v.pen & v.flip;
        e.ferr = ~v.stop;
        e.ovf  = v.rdy;
        e.lat  = 2 + keff / 2 + nbits * keff + 1;
        e.start_cyc = cyc;
        q.push_back(e);
        hold_bit(1'b0, keff);
        k     = BAUD_W'(13);
        eight = ~v.eight;
        pen   = ~v.pen;
        ohel  = ~v.ohel;
        for (int i = 0; i < nd; i++) hold_bit(d[i], keff);
        if (v.pen) hold_bit(par, keff);
        hold_bit(v.stop, keff);
        if (hold_low) hold_bit(1'b0, 40);
        rx = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
        q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        n_vec = 0; n_err = 0; done_cnt = 0;
        rst = 1'b1; rx = 1'b1; k = BAUD_W'(8);
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; rdy_in = 1'b0;

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 8);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 8);
        tbl[3] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8);
        tbl[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34, 8);
        tbl[5] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 2);
        tbl[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 5);
        tbl[7] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8);
        tbl[8] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2B, 6);

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_flags", 32'({perr, ferr, ovf}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i], 1'b0);
            drain();
        end

        // Short low pulse must not start a frame.
        d0 = done_cnt;
        @(posedge clk); #1;
        hold_bit(1'b0, 2);
        hold_bit(1'b1, 30);
        chk("glitch_no_done", 32'(done_cnt), 32'(d0));
        send_frame(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8), 1'b0);
        drain();

        // Stop bit low then line held low: exactly one frame.
        d0 = done_cnt;
        send_frame(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8), 1'b1);
        drain();
        repeat (40) @(posedge clk);
        #1;
        chk("break_one_frame", 32'(done_cnt), 32'(d0 + 1));

        // Reset during data bit 4 of 0x77.
        d0 = done_cnt;
        k = BAUD_W'(8); eight = 1'b1; pen = 1'b0; rdy_in = 1'b0;
        hold_bit(1'b1, 4);
        hold_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) hold_bit(1'b1 ^ (i == 3), 8);
        hold_bit(1'b1, 3);
        rst = 1'b1;
        hold_bit(1'b1, 2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rx_data", 32'(rx_data), 32'd0);
        chk("rst_mid_flags", 32'({rx_done, perr, ferr, ovf}), 32'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        send_frame(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8), 1'b0);
        drain();
        chk("final_done_count", 32'(done_cnt), 32'(d0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
